// File: rtl/i2s_slave_endpoint.sv
`timescale 1ns/1ps
// i2s_slave_endpoint
// Codec-side I2S slave. The I2S master owns BCLK/LRCLK; this block samples
// them on CLK_IN1, deserializes stereo words from SDATA_I, and serializes a
// stereo pair back onto SDATA_O. It is used as a codec stand-in and as a
// loopback target for audio bring-up.
//
// Optional build macro: I2S_SLAVE_LOOPBACK_EN adds the LOOPBACK input. When
// LOOPBACK is 1, each TX frame load takes the RX pair committed at the same
// frame boundary instead of the holding register, and TX_UNDERRUN is
// suppressed.
//
// Ports:
//   CLK_IN1      system clock (BCLK phases each >= 2 CLK_IN1 periods)
//   RESET        synchronous, active-high reset
//   BCLK_I       bit clock from the master (asynchronous)
//   LRCLK_I      word select, 0 = left, 1 = right
//   SDATA_I      serial playback data from the master
//   SDATA_O      serial capture data to the master
//   RX_LEFT/RX_RIGHT  last received stereo pair
//   RX_VALID     one-cycle strobe, RX pair updated
//   TX_LEFT/TX_RIGHT  stereo pair to send
//   TX_VALID     TX pair offered
//   TX_READY     holding register empty
//   TX_UNDERRUN  one-cycle strobe, frame started with empty holding register
//   LOCKED       first right->left transition seen since reset
//   LOOPBACK     (I2S_SLAVE_LOOPBACK_EN only) echo RX stream on TX
module i2s_slave_endpoint #(
    parameter int DATA_WIDTH = 24,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  CLK_IN1,
    input  logic                  RESET,
    input  logic                  BCLK_I,
    input  logic                  LRCLK_I,
    input  logic                  SDATA_I,
    output logic                  SDATA_O,
    output logic [DATA_WIDTH-1:0] RX_LEFT,
    output logic [DATA_WIDTH-1:0] RX_RIGHT,
    output logic                  RX_VALID,
    input  logic [DATA_WIDTH-1:0] TX_LEFT,
    input  logic [DATA_WIDTH-1:0] TX_RIGHT,
    input  logic                  TX_VALID,
    output logic                  TX_READY,
    output logic                  TX_UNDERRUN,
    output logic                  LOCKED
`ifdef I2S_SLAVE_LOOPBACK_EN
    ,
    input  logic                  LOOPBACK
`endif
);

    localparam logic [DATA_WIDTH-1:0] LP_MSB   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  LP_CNT_MAX = {CNT_WIDTH{1'b1}};

    // Synchronizers and edge detect
    logic [1:0]            r_bclk_s;
    logic [1:0]            r_lr_s;
    logic [1:0]            r_sd_s;
    logic                  r_bclk_d;
    logic                  r_rise;
    logic                  r_fall;
    logic                  r_lr_q;
    logic                  r_sd_q;

    // Receive path
    logic                  r_lr_prev;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [DATA_WIDTH-1:0] r_stage_l;
    logic [DATA_WIDTH-1:0] r_rx_left;
    logic [DATA_WIDTH-1:0] r_rx_right;
    logic                  r_rx_valid;
    logic                  r_locked;

    // Transmit path
    logic [DATA_WIDTH-1:0] r_hold_l;
    logic [DATA_WIDTH-1:0] r_hold_r;
    logic                  r_tx_ready;
    logic [DATA_WIDTH-1:0] r_tx_l;
    logic [DATA_WIDTH-1:0] r_tx_r;
    logic                  r_tx_ch;
    logic [CNT_WIDTH-1:0]  r_tx_cnt;
    logic                  r_sdo;
    logic                  r_underrun;

    logic [DATA_WIDTH-1:0] w_rx_mask;
    logic [DATA_WIDTH-1:0] w_rx_shift_nx;
    logic [DATA_WIDTH-1:0] w_tx_mask;
    logic [DATA_WIDTH-1:0] w_tx_word;
    logic                  w_tx_bit;

    // The one-hot mask shifts out to zero once the counter passes the word
    // width, so bits beyond DATA_WIDTH drop out without a range compare.
    // rx_shift is cleared at each slot start, so OR-ing in sd is enough.
    assign w_rx_mask     = LP_MSB >> r_cnt;
    assign w_rx_shift_nx = r_sd_q ? (r_rx_shift | w_rx_mask) : r_rx_shift;

    assign w_tx_mask = LP_MSB >> r_tx_cnt;
    assign w_tx_word = r_tx_ch ? r_tx_r : r_tx_l;
    assign w_tx_bit  = |(w_tx_word & w_tx_mask);

    always_ff @(posedge CLK_IN1) begin
        if (RESET) begin
            r_bclk_s   <= '0;
            r_lr_s     <= '0;
            r_sd_s     <= '0;
            r_bclk_d   <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_lr_q     <= 1'b0;
            r_sd_q     <= 1'b0;
            r_lr_prev  <= 1'b0;
            r_cnt      <= '0;
            r_rx_shift <= '0;
            r_stage_l  <= '0;
            r_rx_left  <= '0;
            r_rx_right <= '0;
            r_rx_valid <= 1'b0;
            r_locked   <= 1'b0;
            r_hold_l   <= '0;
            r_hold_r   <= '0;
            r_tx_ready <= 1'b1;
            r_tx_l     <= '0;
            r_tx_r     <= '0;
            r_tx_ch    <= 1'b0;
            r_tx_cnt   <= '0;
            r_sdo      <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_bclk_s <= {r_bclk_s[0], BCLK_I};
            r_lr_s   <= {r_lr_s[0], LRCLK_I};
            r_sd_s   <= {r_sd_s[0], SDATA_I};
            r_bclk_d <= r_bclk_s[1];
            r_rise   <= r_bclk_s[1] & ~r_bclk_d;
            r_fall   <= ~r_bclk_s[1] & r_bclk_d;
            // lr/sd registered alongside the edge pulse so they line up with it
            r_lr_q   <= r_lr_s[1];
            r_sd_q   <= r_sd_s[1];

            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;

            if (TX_VALID && r_tx_ready) begin
                r_hold_l   <= TX_LEFT;
                r_hold_r   <= TX_RIGHT;
                r_tx_ready <= 1'b0;
            end

            if (r_rise) begin
                if (r_lr_q != r_lr_prev) begin
                    // sd on this edge is the last bit of the slot being closed
                    r_rx_shift <= '0;
                    r_cnt      <= '0;
                    r_lr_prev  <= r_lr_q;
                    r_tx_ch    <= r_lr_q;
                    r_tx_cnt   <= '0;
                    if (!r_lr_prev) begin
                        r_stage_l <= w_rx_shift_nx;
                    end else begin
                        // right->left: frame boundary
                        r_locked <= 1'b1;
                        if (r_locked) begin
                            r_rx_valid <= 1'b1;
                            r_rx_left  <= r_stage_l;
                            r_rx_right <= w_rx_shift_nx;
`ifdef I2S_SLAVE_LOOPBACK_EN
                            if (LOOPBACK) begin
                                r_tx_l <= r_stage_l;
                                r_tx_r <= w_rx_shift_nx;
                            end else
`endif
                            begin
                                // A pair accepted on this same cycle was not
                                // yet in the holding register; it goes out
                                // next frame.
                                if (!r_tx_ready) begin
                                    r_tx_l     <= r_hold_l;
                                    r_tx_r     <= r_hold_r;
                                    r_tx_ready <= 1'b1;
                                end else begin
                                    r_tx_l     <= '0;
                                    r_tx_r     <= '0;
                                    r_underrun <= 1'b1;
                                end
                            end
                        end
                    end
                end else begin
                    r_rx_shift <= w_rx_shift_nx;
                    if (r_cnt != LP_CNT_MAX) r_cnt <= r_cnt + 1'b1;
                end
            end

            if (r_fall) begin
                r_sdo <= r_locked & w_tx_bit;
                if (r_tx_cnt != LP_CNT_MAX) r_tx_cnt <= r_tx_cnt + 1'b1;
            end
        end
    end

    assign SDATA_O     = r_sdo;
    assign RX_LEFT     = r_rx_left;
    assign RX_RIGHT    = r_rx_right;
    assign RX_VALID    = r_rx_valid;
    assign TX_READY    = r_tx_ready;
    assign TX_UNDERRUN = r_underrun;
    assign LOCKED      = r_locked;

endmodule
